// File: rtl/fetch_unit_pkg.sv
// Shared constants and state encoding for the instruction fetch unit.
package fetch_unit_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_t;

    // A redirect target is usable only if it lands on a 32-bit word.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return (addr_lsb == 2'b00);
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter with next-PC select; PC+4 is kept registered alongside PC.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            pcsrc,
    input  logic [XLEN-1:0] pctarget,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4
);

    logic [XLEN-1:0] pc_next_c;

    // Redirect to target or fall through to the sequential address.
    always_comb begin
        pc_next_c = pcsrc ? pctarget : pcplus4;
    end

    // PC and PC+4 update together so both stay stable while held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc      <= RESET_PC;
            pcplus4 <= RESET_PC + PC_STEP;
        end else if (load) begin
            pc      <= pc_next_c;
            pcplus4 <= pc_next_c + PC_STEP;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch: request, wait for response, hold for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_req_ready,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    input  logic            PCSrc,
    input  logic [XLEN-1:0] PCTarget,
    output logic            misaligned
);

    fetch_state_t state;
    fetch_state_t state_next;
    logic         misaligned_next;
    logic         pc_load;
    logic         instr_load;
    logic         consume;

    // Next-state, halt detection and load strobes.
    always_comb begin
        state_next      = state;
        misaligned_next = misaligned;
        pc_load         = 1'b0;
        instr_load      = 1'b0;
        consume         = instr_valid & instr_ready;
        case (state)
            ST_REQ: begin
                if (imem_req_valid && imem_req_ready) begin
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rsp_valid) begin
                    instr_load = 1'b1;
                    state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (consume) begin
                    state_next = ST_REQ;
                    if (PCSrc && !is_word_aligned(PCTarget[1:0])) begin
                        misaligned_next = 1'b1;
                    end else begin
                        pc_load = 1'b1;
                    end
                end
            end
            default: state_next = ST_REQ;
        endcase
    end

    // State plus registered handshake outputs derived from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_REQ;
            misaligned     <= 1'b0;
            imem_req_valid <= 1'b0;
            instr_valid    <= 1'b0;
        end else begin
            state          <= state_next;
            misaligned     <= misaligned_next;
            imem_req_valid <= (state_next == ST_REQ) && !misaligned_next;
            instr_valid    <= (state_next == ST_HOLD);
        end
    end

    // Instruction register captures only the response to our own request.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            Instr <= NOP_INSTR;
        end else if (instr_load) begin
            Instr <= imem_rsp_data;
        end
    end

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .pcsrc    (PCSrc),
        .pctarget (PCTarget),
        .pc       (PC),
        .pcplus4  (PCPlus4)
    );

    assign imem_req_addr = PC;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: default-reset instance plus a wrap-around instance.
module tb_fetch_unit;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pcplus4;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, rsp_valid, instr_valid, instr_ready;
    logic        pcsrc, misaligned;
    logic [31:0] req_addr, rsp_data, instr, pc, pcplus4, pctarget;

    logic        w_req_valid, w_req_ready, w_rsp_valid, w_instr_valid, w_instr_ready;
    logic        w_misaligned;
    logic [31:0] w_req_addr, w_rsp_data, w_instr, w_pc, w_pcplus4;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc;

    fetch_unit dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(req_valid), .imem_req_addr(req_addr), .imem_req_ready(req_ready),
        .imem_rsp_valid(rsp_valid), .imem_rsp_data(rsp_data),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .Instr(instr), .PC(pc), .PCPlus4(pcplus4),
        .PCSrc(pcsrc), .PCTarget(pctarget), .misaligned(misaligned)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr), .imem_req_ready(w_req_ready),
        .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
        .instr_valid(w_instr_valid), .instr_ready(w_instr_ready),
        .Instr(w_instr), .PC(w_pc), .PCPlus4(w_pcplus4),
        .PCSrc(1'b0), .PCTarget(32'h0), .misaligned(w_misaligned)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (req_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_instr_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_ready = 0; rsp_valid = 0; rsp_data = 0; instr_ready = 0; pcsrc = 0; pctarget = 0;
        w_req_ready = 0; w_rsp_valid = 0; w_rsp_data = 0; w_instr_ready = 0;
        tick(); tick();
        tests++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: req_valid=%b instr_valid=%b misaligned=%b required 0 0 0",
                     req_valid, instr_valid, misaligned);
        end
        tests++;
        if (pc !== 32'h0 || pcplus4 !== 32'h4 || instr !== 32'h13 || req_addr !== 32'h0) begin
            fails++;
            $display("FAIL reset_dp: pc=%h pcplus4=%h instr=%h addr=%h required 0 4 13 0",
                     pc, pcplus4, instr, req_addr);
        end
        tests++;
        if (w_pc !== 32'hFFFF_FFFC || w_pcplus4 !== 32'h0) begin
            fails++;
            $display("FAIL reset_wrap: pc=%h pcplus4=%h required fffffffc 00000000", w_pc, w_pcplus4);
        end
        reset = 1'b1;
        exp_pc = 32'h0;
        tests++;
        if (req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_release_early: req_valid=%b required 0", req_valid);
        end
        tick();
        tests++;
        if (req_valid !== 1'b1 || req_addr !== exp_pc) begin
            fails++;
            $display("FAIL reset_first_req: req_valid=%b addr=%h required 1 %h", req_valid, req_addr, exp_pc);
        end
    endtask

    task automatic test_basic();
        bit   ok;
        exp_t e;
        wait_req_valid(ok);
        tests++;
        if (!ok || req_addr !== exp_pc) begin
            fails++;
            $display("FAIL basic_req: ok=%b addr=%h required 1 %h", ok, req_addr, exp_pc);
        end
        req_ready = 1; tick(); req_ready = 0;
        tests++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_wait: req_valid=%b instr_valid=%b required 0 0", req_valid, instr_valid);
        end
        e = '{32'h0000_0293, exp_pc, exp_pc + 32'd4};
        sb.push_back(e);
        rsp_valid = 1; rsp_data = 32'h0000_0293; tick(); rsp_valid = 0;
        tests++;
        if (instr_valid !== 1'b1) begin
            fails++;
            $display("FAIL basic_valid: instr_valid=%b required 1", instr_valid);
        end
        e = sb.pop_front();
        tests++;
        if (instr !== e.instr || pc !== e.pc || pcplus4 !== e.pcplus4) begin
            fails++;
            $display("FAIL basic_instr: instr=%h pc=%h pc4=%h required %h %h %h",
                     instr, pc, pcplus4, e.instr, e.pc, e.pcplus4);
        end
        instr_ready = 1; tick(); instr_ready = 0;
        exp_pc = exp_pc + 32'd4;
        tests++;
        if (req_valid !== 1'b1 || req_addr !== exp_pc || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL basic_next_req: req_valid=%b addr=%h instr_valid=%b required 1 %h 0",
                     req_valid, req_addr, instr_valid, exp_pc);
        end
    endtask

    task automatic test_stall_hold();
        bit   ok;
        exp_t e;
        wait_req_valid(ok);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL stall_wait_req: timeout waiting for req_valid");
        end
        // Memory not ready; a stray response in REQ must be ignored.
        for (int i = 0; i < 5; i++) begin
            rsp_valid = (i == 2); rsp_data = 32'hDEAD_BEEF;
            tick();
            tests++;
            if (req_valid !== 1'b1 || req_addr !== exp_pc || instr_valid !== 1'b0 || instr !== 32'h293) begin
                fails++;
                $display("FAIL stall_cycle%0d: req_valid=%b addr=%h instr_valid=%b instr=%h required 1 %h 0 00000293",
                         i, req_valid, req_addr, instr_valid, instr, exp_pc);
            end
        end
        rsp_valid = 0;
        req_ready = 1; tick(); req_ready = 0;
        e = '{32'h00A0_0513, exp_pc, exp_pc + 32'd4};
        sb.push_back(e);
        rsp_valid = 1; rsp_data = 32'h00A0_0513; tick();
        e = sb.pop_front();
        // Held instruction with a spurious response and don't-care redirect inputs.
        for (int i = 0; i < 4; i++) begin
            rsp_data = 32'hDEAD_BEEF; pcsrc = 1; pctarget = 32'h0000_0103;
            tick();
            tests++;
            if (instr_valid !== 1'b1 || req_valid !== 1'b0 || instr !== e.instr
                || pc !== e.pc || pcplus4 !== e.pcplus4) begin
                fails++;
                $display("FAIL hold_cycle%0d: iv=%b rv=%b instr=%h pc=%h pc4=%h required 1 0 %h %h %h",
                         i, instr_valid, req_valid, instr, pc, pcplus4, e.instr, e.pc, e.pcplus4);
            end
        end
        rsp_valid = 0;
        pcsrc = 1; pctarget = 32'h0000_0100; instr_ready = 1;
        tick();
        instr_ready = 0; pcsrc = 0;
        exp_pc = 32'h0000_0100;
        tests++;
        if (req_valid !== 1'b1 || req_addr !== exp_pc || misaligned !== 1'b0) begin
            fails++;
            $display("FAIL redirect_aligned: rv=%b addr=%h mis=%b required 1 %h 0",
                     req_valid, req_addr, misaligned, exp_pc);
        end
    endtask

    task automatic test_back_to_back();
        bit          ok;
        exp_t        e;
        logic [31:0] data, tgt;
        for (int n = 0; n < 6; n++) begin
            wait_req_valid(ok);
            tests++;
            if (!ok || req_addr !== exp_pc) begin
                fails++;
                $display("FAIL b2b_req%0d: ok=%b addr=%h required 1 %h", n, ok, req_addr, exp_pc);
            end
            repeat ($urandom_range(0, 2)) tick();
            req_ready = 1; tick(); req_ready = 0;
            repeat ($urandom_range(0, 2)) tick();
            data = $urandom;
            e = '{data, exp_pc, exp_pc + 32'd4};
            sb.push_back(e);
            rsp_valid = 1; rsp_data = data; tick(); rsp_valid = 0;
            wait_instr_valid(ok);
            repeat ($urandom_range(0, 2)) tick();
            e = sb.pop_front();
            tests++;
            if (!ok || instr !== e.instr || pc !== e.pc || pcplus4 !== e.pcplus4) begin
                fails++;
                $display("FAIL b2b_instr%0d: ok=%b instr=%h pc=%h pc4=%h required 1 %h %h %h",
                         n, ok, instr, pc, pcplus4, e.instr, e.pc, e.pcplus4);
            end
            tgt = $urandom;
            tgt[1:0] = 2'b00;
            pcsrc = 1'($urandom_range(0, 1));
            pctarget = tgt;
            instr_ready = 1; tick(); instr_ready = 0;
            exp_pc = pcsrc ? tgt : exp_pc + 32'd4;
            pcsrc = 0;
        end
    endtask

    task automatic test_wrap();
        w_req_ready = 1; tick(); w_req_ready = 0;
        w_rsp_valid = 1; w_rsp_data = 32'h0000_0013; tick(); w_rsp_valid = 0;
        tests++;
        if (w_instr_valid !== 1'b1 || w_pc !== 32'hFFFF_FFFC || w_pcplus4 !== 32'h0) begin
            fails++;
            $display("FAIL wrap_hold: iv=%b pc=%h pc4=%h required 1 fffffffc 00000000",
                     w_instr_valid, w_pc, w_pcplus4);
        end
        w_instr_ready = 1; tick(); w_instr_ready = 0;
        tests++;
        if (w_req_valid !== 1'b1 || w_req_addr !== 32'h0 || w_pcplus4 !== 32'h4) begin
            fails++;
            $display("FAIL wrap_next: rv=%b addr=%h pc4=%h required 1 00000000 00000004",
                     w_req_valid, w_req_addr, w_pcplus4);
        end
    endtask

    task automatic test_misaligned();
        bit ok;
        wait_req_valid(ok);
        req_ready = 1; tick(); req_ready = 0;
        rsp_valid = 1; rsp_data = 32'h0000_0063; tick(); rsp_valid = 0;
        pcsrc = 1; pctarget = 32'h0000_0102; instr_ready = 1;
        tick();
        instr_ready = 0; pcsrc = 0;
        for (int i = 0; i < 5; i++) begin
            req_ready = 1;
            tests++;
            if (misaligned !== 1'b1 || req_valid !== 1'b0 || instr_valid !== 1'b0) begin
                fails++;
                $display("FAIL misaligned_halt%0d: mis=%b rv=%b iv=%b required 1 0 0",
                         i, misaligned, req_valid, instr_valid);
            end
            tick();
        end
        req_ready = 0;
    endtask

    task automatic test_reset_in_wait();
        bit ok;
        reset = 0; tick(); reset = 1;
        exp_pc = 32'h0;
        wait_req_valid(ok);
        req_ready = 1; tick(); req_ready = 0;
        reset = 0; tick();
        tests++;
        if (req_valid !== 1'b0 || instr_valid !== 1'b0 || misaligned !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_asserted: rv=%b iv=%b mis=%b required 0 0 0",
                     req_valid, instr_valid, misaligned);
        end
        reset = 1;
        rsp_valid = 1; rsp_data = 32'hDEAD_BEEF; tick(); rsp_valid = 0;
        tests++;
        if (instr_valid !== 1'b0 || req_valid !== 1'b1 || req_addr !== exp_pc || instr !== 32'h13) begin
            fails++;
            $display("FAIL rst_wait_late_rsp: iv=%b rv=%b addr=%h instr=%h required 0 1 %h 00000013",
                     instr_valid, req_valid, req_addr, instr, exp_pc);
        end
        tick();
        tests++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_wait_no_valid: iv=%b required 0", instr_valid);
        end
        req_ready = 1; tick(); req_ready = 0;
        rsp_valid = 1; rsp_data = 32'h0010_0093; tick(); rsp_valid = 0;
        tests++;
        if (instr_valid !== 1'b1 || instr !== 32'h0010_0093 || pc !== exp_pc) begin
            fails++;
            $display("FAIL rst_wait_fresh: iv=%b instr=%h pc=%h required 1 00100093 %h",
                     instr_valid, instr, pc, exp_pc);
        end
        instr_ready = 1; tick(); instr_ready = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_hold();
        test_back_to_back();
        test_wrap();
        test_misaligned();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
